// File: rtl/msxbus_sequencer_if.sv
// Bundles the request, response and MSX bus master signals of msxbus_sequencer.
//   req_*   host request (valid/ready handshake, fields registered on accept)
//   mode    bus master phase select (0 addr, 1 access, 2 ack, 3 release)
//   md_*    MD pin values, per-bit enables, and MD as seen at the pins
//   ready   bus master READY, low = phase complete, asynchronous to clk
//   rsp_*   single-cycle response with read data, bus status and error flag
// The sequencer uses modport master; the host/bus side uses modport slave.
interface msxbus_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_write;
    logic        req_io;
    logic        req_slot;
    logic [1:0]  mode;
    logic [20:0] md_out;
    logic [20:0] md_oe;
    logic [20:0] md_in;
    logic        ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [4:0]  rsp_stat;
    logic        rsp_err;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, req_io, req_slot, md_in, ready,
        output req_ready, mode, md_out, md_oe, rsp_valid, rsp_rdata, rsp_stat, rsp_err
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, req_io, req_slot, md_in, ready,
        input  req_ready, mode, md_out, md_oe, rsp_valid, rsp_rdata, rsp_stat, rsp_err
    );
endinterface

// File: rtl/msxbus_sequencer.sv
// Host-side transaction sequencer for the MAX II MSX bus master. One accepted
// request is walked through the address, handshake-ack, access and release
// phases, paced by the master's READY, and answered with a one-cycle response.
//   clk    rising-edge clock, all state lives here
//   rst_n  asynchronous active-low reset; releases the bus immediately
//   bus    msxbus_sequencer_if.master: request, MODE/MD, READY, response
// TIMEOUT_CYCLES bounds every READY wait; RELEASE_CYCLES is the MODE=3 hold
// after each transaction (must be at least 1).
module msxbus_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4095,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    msxbus_sequencer_if.master  bus
);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RelW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StAddr, StAddrAck, StAccess, StRelease} state_e;

    state_e          state_q;
    logic [1:0]      sync_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic [RelW-1:0] rel_cnt_q;
    logic [15:0]     addr_q;
    logic [7:0]      wdata_q;
    logic            write_q;
    logic            io_q;
    logic            slot_q;
    logic [1:0]      mode_q;
    logic [20:0]     md_out_q;
    logic [20:0]     md_oe_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_rdata_q;
    logic [4:0]      rsp_stat_q;
    logic            rsp_err_q;

    logic rdy_s;
    logic tmo_hit;
    logic rel_done;
    logic unused_md;

    assign rdy_s     = sync_q[1];
    // A wait state has used its whole budget when the count reaches the last value.
    assign tmo_hit   = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
    assign rel_done  = (rel_cnt_q == RelW'(RELEASE_CYCLES - 1));
    assign unused_md = ^bus.md_in[20:13];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            tmo_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            io_q        <= 1'b0;
            slot_q      <= 1'b0;
            mode_q      <= 2'd3;
            md_out_q    <= '0;
            md_oe_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_stat_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus.ready};
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        addr_q    <= bus.req_addr;
                        wdata_q   <= bus.req_wdata;
                        write_q   <= bus.req_write;
                        io_q      <= bus.req_io;
                        slot_q    <= bus.req_slot;
                        state_q   <= StAddr;
                        tmo_cnt_q <= '0;
                        mode_q    <= 2'd0;
                        md_out_q  <= {5'b0, bus.req_addr};
                        md_oe_q   <= 21'h00ffff;
                    end
                end
                StAddr: begin
                    if (!rdy_s) begin
                        state_q   <= StAddrAck;
                        tmo_cnt_q <= '0;
                        mode_q    <= 2'd2;
                        md_out_q  <= '0;
                        md_oe_q   <= '0;
                    end else if (tmo_hit) begin
                        state_q     <= StRelease;
                        rel_cnt_q   <= '0;
                        mode_q      <= 2'd3;
                        md_out_q    <= '0;
                        md_oe_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 8'hff;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end
                StAddrAck: begin
                    if (rdy_s) begin
                        state_q   <= StAccess;
                        tmo_cnt_q <= '0;
                        mode_q    <= 2'd1;
                        // MD[12:8] carries bus status inbound and is never driven.
                        md_out_q  <= {2'b0, slot_q, write_q, io_q, 8'h00,
                                      write_q ? wdata_q : 8'h00};
                        md_oe_q   <= {2'b0, 3'b111, 8'h00, {8{write_q}}};
                    end else if (tmo_hit) begin
                        state_q     <= StRelease;
                        rel_cnt_q   <= '0;
                        mode_q      <= 2'd3;
                        md_out_q    <= '0;
                        md_oe_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 8'hff;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end
                StAccess: begin
                    // Exit is tested first so a completion on the last budget cycle wins.
                    if (!rdy_s) begin
                        rsp_rdata_q <= write_q ? 8'h00 : bus.md_in[7:0];
                        rsp_stat_q  <= bus.md_in[12:8];
                        rsp_err_q   <= 1'b0;
                        state_q     <= StRelease;
                        rel_cnt_q   <= '0;
                        mode_q      <= 2'd3;
                        md_out_q    <= '0;
                        md_oe_q     <= '0;
                    end else if (tmo_hit) begin
                        state_q     <= StRelease;
                        rel_cnt_q   <= '0;
                        mode_q      <= 2'd3;
                        md_out_q    <= '0;
                        md_oe_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 8'hff;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end
                StRelease: begin
                    if (rel_done) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        rel_cnt_q <= rel_cnt_q + RelW'(1);
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    mode_q   <= 2'd3;
                    md_out_q <= '0;
                    md_oe_q  <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.mode      = mode_q;
    assign bus.md_out    = md_out_q;
    assign bus.md_oe     = md_oe_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_stat  = rsp_stat_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_msxbus_sequencer.sv
// Scoreboard bench for msxbus_sequencer: a driver issues directed and random
// requests and queues the expected response; a reactive bus model answers the
// MODE phases; a monitor checks bus pins, phase order and responses.
module tb_msxbus_sequencer;
    localparam int unsigned Tmo = 16;
    localparam int unsigned Rel = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        write;
        logic        io;
        logic        slot;
    } txn_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic [4:0] stat;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic [4:0] stat;
    } bus_data_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bus_auto;
    logic man_ready;
    logic model_ready;
    logic done;
    int   checks;
    int   errors;
    int   drv_stalls;
    txn_t cur;
    logic [4:0] last_stat;
    exp_t      exp_q[$];
    bus_data_t bus_q[$];

    msxbus_sequencer_if bus ();

    msxbus_sequencer #(
        .TIMEOUT_CYCLES(Tmo),
        .RELEASE_CYCLES(Rel)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.ready = bus_auto ? model_ready : man_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Bus master model: reacts to each new MODE after a short random delay.
    initial begin : bus_model
        logic [1:0] last_mode;
        int         wait_cnt;
        bus_data_t  bd;
        last_mode   = 2'd3;
        wait_cnt    = 0;
        model_ready = 1'b1;
        bus.md_in   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus_q.delete();
                last_mode   = 2'd3;
                model_ready = 1'b1;
                wait_cnt    = 0;
            end else begin
                if (bus.mode != last_mode) begin
                    last_mode = bus.mode;
                    wait_cnt  = (bus.mode == 2'd3) ? 0 : int'($urandom_range(0, 3));
                    if (bus.mode == 2'd1 && bus_q.size() > 0) begin
                        bd        = bus_q.pop_front();
                        bus.md_in = {8'($urandom), bd.stat, bd.rdata};
                    end
                end else if (wait_cnt > 0) begin
                    wait_cnt--;
                end
                if (wait_cnt == 0) model_ready = (bus.mode == 2'd2 || bus.mode == 2'd3);
            end
        end
    end

    task automatic garbage();
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 8'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_io    = 1'($urandom);
        bus.req_slot  = 1'($urandom);
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input txn_t t, input logic [7:0] brd, input logic [4:0] bst,
                        input bit keep, input bit tmo);
        exp_t e;
        int   n;
        n = 0;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 300) begin
            garbage();
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready) begin
            drv_stalls++;
            bus.req_valid = 1'b0;
            return;
        end
        bus.req_addr  = t.addr;
        bus.req_wdata = t.wdata;
        bus.req_write = t.write;
        bus.req_io    = t.io;
        bus.req_slot  = t.slot;
        cur = t;
        if (tmo) begin
            e = '{rdata: 8'hff, stat: last_stat, err: 1'b1};
        end else begin
            bus_q.push_back('{rdata: brd, stat: bst});
            e = '{rdata: t.write ? 8'h00 : brd, stat: bst, err: 1'b0};
            last_stat = bst;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        garbage();
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) drv_stalls++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.addr  = 16'($urandom);
        t.wdata = 8'($urandom);
        t.write = 1'($urandom);
        t.io    = 1'($urandom);
        t.slot  = 1'($urandom);
        return t;
    endfunction

    initial begin : driver
        txn_t t;
        int   n;
        bit   keep;
        done       = 1'b0;
        drv_stalls = 0;
        last_stat  = '0;
        bus_auto   = 1'b1;
        man_ready  = 1'b1;
        bus.req_valid = 1'b0;
        garbage();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Memory write and IO read from the test plan.
        send('{addr: 16'h4000, wdata: 8'ha5, write: 1'b1, io: 1'b0, slot: 1'b0},
             8'h5a, 5'b01001, 1'b0, 1'b0);
        wait_idle();
        send('{addr: 16'h0098, wdata: 8'h77, write: 1'b0, io: 1'b1, slot: 1'b1},
             8'h3c, 5'b10110, 1'b0, 1'b0);
        wait_idle();

        // Back-to-back with REQ_VALID held high.
        send(rand_txn(), 8'($urandom), 5'($urandom), 1'b1, 1'b0);
        send(rand_txn(), 8'($urandom), 5'($urandom), 1'b0, 1'b0);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            keep = 1'($urandom);
            send(rand_txn(), 8'($urandom), 5'($urandom), keep, 1'b0);
            if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        wait_idle();

        // READY stuck high in the address phase.
        bus_auto = 1'b0;
        send(rand_txn(), 8'h00, 5'h00, 1'b0, 1'b1);
        wait_idle();
        bus_auto = 1'b1;

        // Reset while a write sits in the access phase.
        t = rand_txn();
        t.write = 1'b1;
        send(t, 8'($urandom), 5'($urandom), 1'b0, 1'b0);
        n = 0;
        while (bus.mode != 2'd1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.mode != 2'd1) drv_stalls++;
        #1 rst_n = 1'b0;
        last_stat = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(rand_txn(), 8'($urandom), 5'($urandom), 1'b0, 1'b0);
        wait_idle();

        // Sub-period READY glitch straddling a clock edge in the address phase.
        bus_auto = 1'b0;
        t = rand_txn();
        t.write = 1'b0;
        send(t, 8'($urandom), 5'($urandom), 1'b0, 1'b0);
        #6 man_ready = 1'b0;
        #4 man_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 bus_auto = 1'b1;
        wait_idle();

        done = 1'b1;
    end

    initial begin : monitor
        logic [1:0]  prev_mode;
        logic        prev_rsp;
        logic        busy;
        logic        seen_active;
        logic        legal;
        int          addr_run;
        int          rel_run;
        int          cyc;
        exp_t        e;
        logic [20:0] e_oe;
        logic [20:0] e_out;
        checks      = 0;
        errors      = 0;
        prev_mode   = 2'd3;
        prev_rsp    = 1'b0;
        busy        = 1'b0;
        seen_active = 1'b0;
        addr_run    = 0;
        rel_run     = 0;
        cyc         = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            cyc++;
            if (cyc > 20000) begin
                checks++;
                errors++;
                $display("FAIL watchdog: run still active after %0d samples, required completion",
                         cyc);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            if (!rst_n) begin
                #1;
                chk("rst_mode", 32'(bus.mode), 32'd3);
                chk("rst_md_oe", 32'(bus.md_oe), 32'd0);
                chk("rst_md_out", 32'(bus.md_out), 32'd0);
                chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
                chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
                chk("rst_rsp_stat", 32'(bus.rsp_stat), 32'd0);
                chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
                exp_q.delete();
                prev_mode   = 2'd3;
                prev_rsp    = 1'b0;
                busy        = 1'b0;
                seen_active = 1'b0;
                addr_run    = 0;
                rel_run     = 0;
            end else if (done) begin
                chk("queue_drained", 32'(exp_q.size()), 32'd0);
                chk("driver_stalls", 32'(drv_stalls), 32'd0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end else begin
                if (bus.mode != prev_mode) begin
                    legal = (prev_mode == 2'd3 && bus.mode == 2'd0) ||
                            (prev_mode == 2'd0 && (bus.mode == 2'd2 || bus.mode == 2'd3)) ||
                            (prev_mode == 2'd2 && (bus.mode == 2'd1 || bus.mode == 2'd3)) ||
                            (prev_mode == 2'd1 && bus.mode == 2'd3);
                    chk("mode_step_legal", 32'(legal), 32'd1);
                    if (bus.mode == 2'd0) addr_run = 0;
                    prev_mode = bus.mode;
                end
                if (bus.mode == 2'd0) addr_run++;
                if (bus.mode != 2'd3) begin
                    seen_active = 1'b1;
                    rel_run     = 0;
                end else if (seen_active && !bus.rsp_valid) begin
                    rel_run++;
                end

                e_oe  = '0;
                e_out = '0;
                if (bus.mode == 2'd0) begin
                    e_oe  = 21'h00ffff;
                    e_out = {5'b0, cur.addr};
                end else if (bus.mode == 2'd1) begin
                    e_oe  = {2'b0, 3'b111, 8'h00, cur.write ? 8'hff : 8'h00};
                    e_out = {2'b0, cur.slot, cur.write, cur.io, 8'h00,
                             cur.write ? cur.wdata : 8'h00};
                end
                chk("md_oe", 32'(bus.md_oe), 32'(e_oe));
                chk("md_out", 32'(bus.md_out), 32'(e_out));

                if (busy && !bus.rsp_valid) chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
                chk("rsp_single_pulse", 32'(prev_rsp && bus.rsp_valid), 32'd0);
                prev_rsp = bus.rsp_valid;

                if (bus.rsp_valid) begin
                    busy = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1, required none pending at %0t",
                                 $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                        chk("rsp_stat", 32'(bus.rsp_stat), 32'(e.stat));
                        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                        chk("release_len", 32'(rel_run), 32'(Rel));
                        if (e.err) chk("timeout_len", 32'(addr_run), 32'(Tmo));
                    end
                    seen_active = 1'b0;
                end
                if (bus.req_valid && bus.req_ready) busy = 1'b1;
            end
        end
    end
endmodule
